idiv_seq: RTL and testbench

//  - Sequential unsigned integer divider; the inverse of the team's combinational array multiplier.
//  - Restoring algorithm, one quotient bit per clock.
//  - Sits beside the multiplier in the arithmetic datapath; driven by a start/done handshake.
//  - Returns quotient, remainder and a divide-by-zero flag.

---
 rtl/idiv_pkg.sv | 11 +
 rtl/idiv_step.sv | 22 ++
 rtl/idiv_seq.sv | 125 ++++++++++++
 tb/tb_idiv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/idiv_pkg.sv
// Shared types and helpers for the sequential restoring divider (idiv_seq).
package idiv_pkg;

  typedef enum logic [1:0] {IDIV_IDLE, IDIV_CALC, IDIV_DONE} idiv_state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int idiv_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/idiv_step.sv
// One restoring-division cell: shift in the next dividend bit, trial-subtract the divisor.
// The kept remainder is always below the divisor, so WIDTH bits suffice between steps.
module idiv_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  // Only used when the trial succeeds, where the true difference fits in WIDTH bits.
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/idiv_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining IDIV_SIGNED_EN.
module idiv_seq
  import idiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivZero,
  output idiv_state_t      oState
);

  // Handshake: iStart is accepted on any edge where state != CALC (IDLE or DONE);
  // oDone is a one-cycle pulse with results valid that cycle and held afterwards.

  localparam int CW = idiv_cnt_w(WIDTH);

  idiv_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_rem, r_q, r_div, r_quo, r_remo;
  logic             r_dz;
  logic [WIDTH-1:0] w_rem_nxt, w_q_fin, w_dvd_in, w_div_in, w_quo_fix, w_rem_fix;
  logic             w_qbit, w_accept, w_last;

`ifdef IDIV_SIGNED_EN
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             w_dvd_neg, w_div_neg;

  assign w_dvd_neg = iDividend[WIDTH-1];
  assign w_div_neg = iDivisor[WIDTH-1];
  assign w_dvd_in  = w_dvd_neg ? -iDividend : iDividend;
  assign w_div_in  = w_div_neg ? -iDivisor : iDivisor;
  // Divide by zero bypasses the sign fix-up so the raw dividend comes back untouched.
  assign w_quo_fix = (r_div == '0) ? '1 : (r_neg_q ? -w_q_fin : w_q_fin);
  assign w_rem_fix = (r_div == '0) ? r_dvd_raw : (r_neg_r ? -w_rem_nxt : w_rem_nxt);
`else
  assign w_dvd_in  = iDividend;
  assign w_div_in  = iDivisor;
  assign w_quo_fix = w_q_fin;
  assign w_rem_fix = w_rem_nxt;
`endif

  idiv_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_q_fin   = {r_q[WIDTH-2:0], w_qbit};
  assign w_accept  = iStart && (r_state != IDIV_CALC);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = (r_state == IDIV_CALC) && (w_cnt_nxt == CW'(WIDTH));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDIV_IDLE: if (iStart) w_state_nxt = IDIV_CALC;
      IDIV_CALC: if (w_last) w_state_nxt = IDIV_DONE;
      IDIV_DONE: w_state_nxt = iStart ? IDIV_CALC : IDIV_IDLE;
      default:   w_state_nxt = IDIV_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_remo <= '0;
      r_dz   <= 1'b0;
`ifdef IDIV_SIGNED_EN
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dvd_raw <= '0;
`endif
    end else if (w_accept) begin
      r_div <= w_div_in;
      r_q   <= w_dvd_in;
      r_rem <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
`ifdef IDIV_SIGNED_EN
      r_neg_q   <= w_dvd_neg ^ w_div_neg;
      r_neg_r   <= w_dvd_neg;
      r_dvd_raw <= iDividend;
`endif
    end else if (r_state == IDIV_CALC) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_fin;
      r_cnt <= w_cnt_nxt;
      // Results land on the edge that enters DONE, so they are valid with oDone.
      if (w_last) begin
        r_quo  <= w_quo_fix;
        r_remo <= w_rem_fix;
        r_dz   <= (r_div == '0);
      end
    end
  end

  assign oBusy      = (r_state == IDIV_CALC);
  assign oDone      = (r_state == IDIV_DONE);
  assign oQuotient  = r_quo;
  assign oRemainder = r_remo;
  assign oDivZero   = r_dz;
  assign oState     = r_state;

endmodule

// File: tb/tb_idiv_seq.sv
// Self-checking bench for idiv_seq: directed steps, expected-result queue, latency and hold checks.
module tb_idiv_seq;
  import idiv_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         Reset;
  logic         iStart;
  logic [W-1:0] iDividend, iDivisor;
  logic         oBusy, oDone, oDivZero;
  logic [W-1:0] oQuotient, oRemainder;
  idiv_state_t  oState;

  int             n_cmp;
  int             n_err;
  logic [2*W:0]   exp_q[$];
  logic [2*W:0]   last_e;
  logic [W-1:0]   obs_q, obs_r;

  idiv_seq #(.WIDTH(W)) dut (
    .Clock      (clk),
    .Reset      (Reset),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivZero   (oDivZero),
    .oState     (oState)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {divzero, quotient, remainder}
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
`ifdef IDIV_SIGNED_EN
    int sa, sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      return {1'b1, q, r};
    end
`ifdef IDIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    q  = W'(sa / sb);
    r  = W'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Driver: present operands with iStart for one accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W:0] e, input bit do_push);
    iDividend = a;
    iDivisor  = b;
    iStart    = 1'b1;
    if (do_push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    iStart    = 1'b0;
    iDividend = W'($urandom);
    iDivisor  = W'($urandom);
  endtask

  // Waits for oDone (bounded), checks latency and pops/compares the scoreboard.
  task automatic wait_done(input string tag, input int k0);
    int           k;
    bit           got;
    logic [2*W:0] e;
    k   = k0;
    got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, "_busy"}, oBusy, 1);
      if (oDone) got = 1'b1;
    end
    check({tag, "_latency"}, k, 17);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    last_e = e;
    check({tag, "_q"},  oQuotient,  e[2*W-1:W]);
    check({tag, "_r"},  oRemainder, e[W-1:0]);
    check({tag, "_dz"}, oDivZero,   e[2*W]);
    obs_q = oQuotient;
    obs_r = oRemainder;
  endtask

  task automatic check_hold(input string tag);
    @(negedge clk);
    check({tag, "_done_drop"}, oDone, 0);
    check({tag, "_hold_q"}, oQuotient,  last_e[2*W-1:W]);
    check({tag, "_hold_r"}, oRemainder, last_e[W-1:0]);
    check({tag, "_state"},  oState, IDIV_IDLE);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           seen;
    n_cmp     = 0;
    n_err     = 0;
    Reset     = 1'b1;
    iStart    = 1'b0;
    iDividend = '0;
    iDivisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_q", oQuotient, 0);
    check("rst_r", oRemainder, 0);
    check("rst_dz", oDivZero, 0);
    check("rst_state", oState, IDIV_IDLE);
    Reset = 1'b0;
    @(negedge clk);

    start_op(16'd1000, 16'd7, {1'b0, 16'd142, 16'd6}, 1'b1);
    wait_done("d1000_7", 0);
    check_hold("d1000_7");

    start_op(16'hFFFF, 16'd1, {1'b0, 16'hFFFF, 16'd0}, 1'b1);
    wait_done("dffff_1", 0);
    start_op(16'd3, 16'd10, {1'b0, 16'd0, 16'd3}, 1'b1);
    wait_done("d3_10", 0);
    start_op(16'd0, 16'd5, {1'b0, 16'd0, 16'd0}, 1'b1);
    wait_done("d0_5", 0);
    start_op(16'd5, 16'd0, {1'b1, 16'hFFFF, 16'd5}, 1'b1);
    wait_done("d5_0", 0);
    check_hold("d5_0");

`ifdef IDIV_SIGNED_EN
    start_op(16'hFFF9, 16'd2, {1'b0, 16'hFFFD, 16'hFFFF}, 1'b1);
    wait_done("sgn_fff9_2", 0);
    start_op(16'h8000, 16'hFFFF, {1'b0, 16'h8000, 16'h0000}, 1'b1);
    wait_done("sgn_min_m1", 0);
`else
    start_op(16'hFFF9, 16'd2, {1'b0, 16'h7FFC, 16'd1}, 1'b1);
    wait_done("uns_fff9_2", 0);
    start_op(16'h8000, 16'hFFFF, {1'b0, 16'h0000, 16'h8000}, 1'b1);
    wait_done("uns_8000_ffff", 0);
`endif
    start_op(16'hFFF9, 16'd0, {1'b1, 16'hFFFF, 16'hFFF9}, 1'b1);
    wait_done("dfff9_0", 0);

    // Start request during CALC must be ignored.
    start_op(16'd1000, 16'd7, {1'b0, 16'd142, 16'd6}, 1'b1);
    repeat (3) @(negedge clk);
    iDividend = 16'd500;
    iDivisor  = 16'd3;
    iStart    = 1'b1;
    @(negedge clk);
    iStart    = 1'b0;
    wait_done("ignore", 4);
    check_hold("ignore");

    // Back-to-back: second start presented in the DONE cycle.
    start_op(16'd1234, 16'd56, model(16'd1234, 16'd56), 1'b1);
    wait_done("b2b_a", 0);
    start_op(16'd40000, 16'd3, model(16'd40000, 16'd3), 1'b1);
    wait_done("b2b_b", 0);
    check_hold("b2b_b");

    // Asynchronous reset in the middle of CALC aborts the operation.
    start_op(16'd1000, 16'd7, '0, 1'b0);
    repeat (7) @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", oBusy, 0);
    check("abort_done", oDone, 0);
    check("abort_q", oQuotient, 0);
    check("abort_r", oRemainder, 0);
    check("abort_dz", oDivZero, 0);
    @(negedge clk);
    Reset = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (oDone) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    start_op(16'd100, 16'd9, {1'b0, 16'd11, 16'd1}, 1'b1);
    wait_done("d100_9", 0);

    repeat (10) begin
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(1, 65535));
      start_op(a, b, model(a, b), 1'b1);
      wait_done("rand", 0);
`ifndef IDIV_SIGNED_EN
      check("rand_identity", 32'(obs_q) * 32'(b) + 32'(obs_r), 32'(a));
      check("rand_r_lt_d", (obs_r < b), 1);
`endif
    end

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
